// File: rtl/handshake_pkg.sv
// Shared constants and helpers for the handshake slave: data width, sequence
// wrap points, the sequence increment and the FIFO level width.
package handshake_pkg;

   localparam int DATA_W  = 8;
   localparam int SEQ_MIN = 2;
   localparam int SEQ_MAX = 255;

   // Occupancy counter must hold 0..depth inclusive.
   function automatic int unsigned level_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int unsigned seq_inc(input int unsigned x,
                                           input int unsigned smin,
                                           input int unsigned smax);
      return (x == smax) ? smin : x + 1;
   endfunction

endpackage

// File: rtl/handshake_sync_fifo.sv
// Single-clock FIFO with show-ahead head word; pushes when full and pops when
// empty are ignored.
module handshake_sync_fifo
   import handshake_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int LVL_W = level_w(DEPTH)
) (
   input  logic             sys_clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [LVL_W-1:0] level,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge sys_clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/handshake_slave.sv
// Receiving end of the valid/ready byte handshake: buffers words, drains them
// at a fixed rate to a local sink and checks the +1 data sequence.
module handshake_slave #(
   parameter int DATA_W       = handshake_pkg::DATA_W,
   parameter int FIFO_DEPTH   = 8,
   parameter int READY_LAT    = 1,
   parameter int DRAIN_PERIOD = 4,
   parameter int SEQ_MIN      = handshake_pkg::SEQ_MIN,
   parameter int SEQ_MAX      = handshake_pkg::SEQ_MAX
) (
   input  logic                                           sys_clk,
   input  logic                                           reset_n,
   input  logic                                           vaild,
   input  logic [DATA_W-1:0]                              master_data,
   input  logic                                           sink_hold,
   output logic                                           ready,
   output logic [DATA_W-1:0]                              slave_data,
   output logic                                           slave_data_vaild,
   output logic [handshake_pkg::level_w(FIFO_DEPTH)-1:0]  fifo_level,
   output logic [15:0]                                    rx_count,
   output logic [15:0]                                    err_count
);

   import handshake_pkg::*;

   localparam int LVL_W = level_w(FIFO_DEPTH);
   localparam int CNT_W = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_PERIOD - 1);
   localparam logic [LVL_W-1:0] RDY_THRESH = LVL_W'(FIFO_DEPTH - 1 - READY_LAT);

   // Handshake: a word transfers on every posedge where vaild && ready are both
   // high; ready depends only on registered occupancy, never on vaild or data.
   logic              accept;
   logic              wr_ok;
   logic              overflow;
   logic              pop;
   logic              full;
   logic              empty;
   logic [DATA_W-1:0] head;
   logic [LVL_W-1:0]  lvl_next;
   logic              rdy_int;
   logic [CNT_W-1:0]  drain_cnt;
   logic              seeded;
   logic [DATA_W-1:0] exp_word;
   logic              seq_err;

   assign accept   = vaild && ready;
   assign wr_ok    = accept && !full;
   assign overflow = accept && full;
   assign pop      = (drain_cnt == DRAIN_LAST) && !empty && !sink_hold;
   assign seq_err  = accept && seeded && (master_data != exp_word);

   handshake_sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH),
      .LVL_W (LVL_W)
   ) u_fifo (
      .sys_clk (sys_clk),
      .reset_n (reset_n),
      .push    (wr_ok),
      .pop     (pop),
      .wdata   (master_data),
      .rdata   (head),
      .level   (fifo_level),
      .full    (full),
      .empty   (empty)
   );

   always_comb begin
      lvl_next = fifo_level;
      if (wr_ok && !pop)      lvl_next = fifo_level + LVL_W'(1);
      else if (!wr_ok && pop) lvl_next = fifo_level - LVL_W'(1);
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) rdy_int <= 1'b0;
      else          rdy_int <= (lvl_next <= RDY_THRESH);
   end

   // The extra stage is covered by the lower threshold, so no overflow occurs.
   generate
      if (READY_LAT == 1) begin : g_rdy_flop
         logic ready_q;
         always_ff @(posedge sys_clk or negedge reset_n) begin
            if (!reset_n) ready_q <= 1'b0;
            else          ready_q <= rdy_int;
         end
         assign ready = ready_q;
      end else begin : g_rdy_direct
         assign ready = rdy_int;
      end
   endgenerate

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         drain_cnt        <= '0;
         slave_data       <= '0;
         slave_data_vaild <= 1'b0;
      end else begin
         drain_cnt        <= (drain_cnt == DRAIN_LAST) ? '0 : drain_cnt + CNT_W'(1);
         slave_data_vaild <= pop;
         if (pop) slave_data <= head;
      end
   end

   // Every accepted word reseeds the expectation, so one bad word costs one error.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         seeded    <= 1'b0;
         exp_word  <= '0;
         rx_count  <= '0;
         err_count <= '0;
      end else begin
         if (accept) begin
            seeded   <= 1'b1;
            exp_word <= DATA_W'(seq_inc(32'(master_data), SEQ_MIN, SEQ_MAX));
         end
         if (wr_ok && (rx_count != 16'hFFFF))                   rx_count  <= rx_count + 16'd1;
         if ((overflow || seq_err) && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_handshake_slave.sv
// Directed bench for handshake_slave: a free-drain instance carries the main
// scenarios, a DRAIN_PERIOD=4 instance checks the drain rate.
module tb_handshake_slave;

   logic        sys_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        vaild, sink_hold;
   logic [7:0]  master_data;
   logic        ready, slave_data_vaild;
   logic [7:0]  slave_data;
   logic [3:0]  fifo_level;
   logic [15:0] rx_count, err_count;

   logic        v4, h4;
   logic [7:0]  d4;
   logic        ready4, svalid4;
   logic [7:0]  sdata4;
   logic [3:0]  level4;
   logic [15:0] rx4, err4;

   int          checks = 0;
   int          errors = 0;
   int          pulse_cnt = 0;
   int          cyc = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  got4_q[$];
   int          t4_q[$];

   handshake_slave #(.FIFO_DEPTH(8), .READY_LAT(1), .DRAIN_PERIOD(1)) dut (
      .sys_clk(sys_clk), .reset_n(reset_n), .vaild(vaild), .master_data(master_data),
      .sink_hold(sink_hold), .ready(ready), .slave_data(slave_data),
      .slave_data_vaild(slave_data_vaild), .fifo_level(fifo_level),
      .rx_count(rx_count), .err_count(err_count)
   );

   handshake_slave #(.FIFO_DEPTH(8), .READY_LAT(1), .DRAIN_PERIOD(4)) dut4 (
      .sys_clk(sys_clk), .reset_n(reset_n), .vaild(v4), .master_data(d4),
      .sink_hold(h4), .ready(ready4), .slave_data(sdata4),
      .slave_data_vaild(svalid4), .fifo_level(level4),
      .rx_count(rx4), .err_count(err4)
   );

   // clock / reset
   always #5 sys_clk = ~sys_clk;
   initial forever begin
      @(posedge sys_clk);
      cyc++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, output logic acc);
      vaild = 1'b1;
      master_data = d;
      @(negedge sys_clk);
      acc = ready;
      @(posedge sys_clk);
      #1;
      if (acc) exp_q.push_back(d);
   endtask

   task automatic idle(input int n);
      vaild = 1'b0;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      vaild = 1'b0;
      sink_hold = 1'b0;
      reset_n = 1'b0;
      exp_q.delete();
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      tick();
   endtask

   // scoreboard for the free-drain instance
   initial forever begin
      logic [7:0] e;
      @(negedge sys_clk);
      if (reset_n && slave_data_vaild) begin
         pulse_cnt++;
         check("sb_queue_nonempty", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_data", slave_data, e);
         end
      end
   end

   // capture for the DRAIN_PERIOD=4 instance
   initial forever begin
      @(negedge sys_clk);
      if (reset_n && svalid4) begin
         got4_q.push_back(sdata4);
         t4_q.push_back(cyc);
      end
   end

   initial begin
      logic       acc;
      logic [7:0] d8;
      int         nacc;
      logic [7:0] seq3 [5] = '{8'd253, 8'd254, 8'd255, 8'd2, 8'd3};

      vaild = 1'b0; master_data = '0; sink_hold = 1'b0;
      v4 = 1'b0; d4 = '0; h4 = 1'b0;
      repeat (3) tick();

      // reset state and warm-up
      check("rst_ready", ready, 0);
      check("rst_level", fifo_level, 0);
      check("rst_rx", rx_count, 0);
      check("rst_err", err_count, 0);
      check("rst_sdata", slave_data, 0);
      check("rst_svalid", slave_data_vaild, 0);
      reset_n = 1'b1;
      tick();
      check("warm_ready_e1", ready, 0);
      tick();
      check("warm_ready_e2", ready, 1);

      // 1: free sink streaming 2..40
      pulse_cnt = 0; nacc = 0;
      for (int d = 2; d <= 40; d++) begin
         send(8'(d), acc);
         if (!acc) nacc++;
      end
      idle(4);
      check("t1_ready_drops", nacc, 0);
      check("t1_rx", rx_count, 39);
      check("t1_err", err_count, 0);
      check("t1_level", fifo_level, 0);
      check("t1_sb_left", exp_q.size(), 0);
      check("t1_pulses", pulse_cnt, 39);

      // 2: held sink fills to exactly 8, then drains in order
      do_reset();
      pulse_cnt = 0; nacc = 0; d8 = 8'd2;
      sink_hold = 1'b1;
      for (int i = 0; i < 16; i++) begin
         send(d8, acc);
         if (acc) begin
            nacc++;
            d8 = d8 + 8'd1;
         end
      end
      idle(1);
      check("t2_accepted", nacc, 8);
      check("t2_level", fifo_level, 8);
      check("t2_ready", ready, 0);
      check("t2_rx", rx_count, 8);
      check("t2_err", err_count, 0);
      check("t2_no_pop", pulse_cnt, 0);
      sink_hold = 1'b0;
      idle(12);
      check("t2_sb_left", exp_q.size(), 0);
      check("t2_pulses", pulse_cnt, 8);
      check("t2_ready_back", ready, 1);
      check("t2_level_end", fifo_level, 0);

      // 3: sequence wrap, gap, reseed
      do_reset();
      for (int i = 0; i < 5; i++) send(seq3[i], acc);
      idle(1);
      check("t3_err_wrap", err_count, 0);
      send(8'd5, acc);
      idle(1);
      check("t3_err_gap", err_count, 1);
      send(8'd6, acc);
      idle(4);
      check("t3_err_reseed", err_count, 1);
      check("t3_rx", rx_count, 7);
      check("t3_sb_left", exp_q.size(), 0);

      // 4: data toggling with vaild low is ignored
      pulse_cnt = 0;
      vaild = 1'b0;
      for (int i = 0; i < 20; i++) begin
         master_data = (i % 2 == 0) ? 8'hA5 : 8'h5A;
         tick();
      end
      check("t4_rx", rx_count, 7);
      check("t4_level", fifo_level, 0);
      check("t4_pulses", pulse_cnt, 0);

      // 5: push and pop on the same edge at level 7
      pulse_cnt = 0; nacc = 0;
      sink_hold = 1'b1;
      for (int d = 7; d <= 13; d++) begin
         send(8'(d), acc);
         if (acc) nacc++;
      end
      check("t5_fill", nacc, 7);
      sink_hold = 1'b0;
      send(8'd14, acc);
      vaild = 1'b0;
      check("t5_push_acc", acc, 1);
      check("t5_level", fifo_level, 7);
      check("t5_ready", ready, 0);
      check("t5_err", err_count, 1);
      idle(14);
      check("t5_sb_left", exp_q.size(), 0);
      check("t5_pulses", pulse_cnt, 8);
      check("t5_rx", rx_count, 15);

      // 6: reset mid-burst at level 5
      sink_hold = 1'b1;
      for (int d = 15; d <= 19; d++) send(8'(d), acc);
      vaild = 1'b0;
      check("t6_level_pre", fifo_level, 5);
      #2;
      reset_n = 1'b0;
      exp_q.delete();
      sink_hold = 1'b0;
      #1;
      check("t6_ready", ready, 0);
      check("t6_level", fifo_level, 0);
      check("t6_rx", rx_count, 0);
      check("t6_err", err_count, 0);
      check("t6_sdata", slave_data, 0);
      check("t6_svalid", slave_data_vaild, 0);
      tick();
      reset_n = 1'b1;
      tick();
      check("t6_ready_e1", ready, 0);
      tick();
      check("t6_ready_e2", ready, 1);
      pulse_cnt = 0;
      send(8'd100, acc);
      send(8'd101, acc);
      idle(1);
      check("t6_seed_no_err", err_count, 0);
      send(8'd103, acc);
      idle(6);
      check("t6_err_after", err_count, 1);
      check("t6_rx_after", rx_count, 3);
      check("t6_pulses", pulse_cnt, 3);

      // 7: DRAIN_PERIOD=4 pops one word every four cycles
      got4_q.delete(); t4_q.delete();
      for (int d = 2; d <= 4; d++) begin
         v4 = 1'b1;
         d4 = 8'(d);
         tick();
      end
      v4 = 1'b0;
      repeat (24) tick();
      check("t7_pops", got4_q.size(), 3);
      if (got4_q.size() == 3) begin
         check("t7_data0", got4_q[0], 2);
         check("t7_data1", got4_q[1], 3);
         check("t7_data2", got4_q[2], 4);
         check("t7_gap0", t4_q[1] - t4_q[0], 4);
         check("t7_gap1", t4_q[2] - t4_q[1], 4);
      end
      check("t7_rx", rx4, 3);
      check("t7_err", err4, 0);
      check("t7_level", level4, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
